// File: rtl/sw_pkg.sv
// sw_pkg: shared encodings for the stopwatch/clock button controller.
package sw_pkg;
   typedef enum logic [1:0] {
      FIELD_NONE = 2'b00,
      FIELD_SEC  = 2'b01,
      FIELD_MIN  = 2'b10,
      FIELD_HOUR = 2'b11
   } field_t;

   typedef enum logic {
      MODE_SW  = 1'b0,
      MODE_CLK = 1'b1
   } mode_t;

   typedef enum logic {
      SW_STOP = 1'b0,
      SW_RUN  = 1'b1
   } sw_state_t;

   function automatic field_t next_field(input field_t f);
      return field_t'(f + 2'd1);
   endfunction
endpackage

// File: rtl/btn_edge_det.sv
// btn_edge_det: two-flop sampler with a registered rising-edge event; flops reset
// high so a button already held through reset release yields no event.
module btn_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_lvl,
   output logic o_evt
);
   logic r_d1, r_d2, r_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d1  <= 1'b1;
         r_d2  <= 1'b1;
         r_evt <= 1'b0;
      end else begin
         r_d1  <= i_lvl;
         r_d2  <= r_d1;
         r_evt <= r_d1 & ~r_d2;
      end
   end

   assign o_evt = r_evt;
endmodule

// File: rtl/sw_btn_ctrl.sv
// sw_btn_ctrl: turns debounced button pulses into stopwatch run/clear, display mode
// and clock-edit commands, with an idle timeout that drops out of field editing.
module sw_btn_ctrl
   import sw_pkg::*;
#(
   parameter int unsigned EDIT_TIMEOUT = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_run,
   input  logic       i_btn_clear,
   input  logic       i_btn_mode,
   input  logic       i_btn_sel,
   output logic       o_sw_run,
   output logic       o_sw_clear,
   output logic       o_mode,
   output logic [1:0] o_edit_field,
   output logic       o_inc,
   output logic       o_dec
);
   localparam int CW = $clog2(EDIT_TIMEOUT);

   logic [3:0]    w_lvl, w_evt;
   sw_state_t     r_state, w_state_n;
   mode_t         r_mode, w_mode_n;
   field_t        r_field, w_field_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic          r_clear, r_inc, r_dec, w_clear_n, w_inc_n, w_dec_n;

   assign w_lvl = {i_btn_sel, i_btn_mode, i_btn_clear, i_btn_run};

   for (genvar i = 0; i < 4; i++) begin : g_det
      btn_edge_det u_det (.clk(clk), .rst(rst), .i_lvl(w_lvl[i]), .o_evt(w_evt[i]));
   end

   // Priority clear > run > mode > sel; lower-priority events in the same cycle are dropped.
   always_comb begin
      w_state_n = r_state;
      w_mode_n  = r_mode;
      w_field_n = r_field;
      w_cnt_n   = r_cnt + 1'b1;
      w_clear_n = 1'b0;
      w_inc_n   = 1'b0;
      w_dec_n   = 1'b0;
      if (w_evt[1]) begin
         if (r_mode == MODE_CLK) w_dec_n = (r_field != FIELD_NONE);
         else w_clear_n = (r_state == SW_STOP);
      end else if (w_evt[0]) begin
         if (r_mode == MODE_CLK) w_inc_n = (r_field != FIELD_NONE);
         else w_state_n = (r_state == SW_STOP) ? SW_RUN : SW_STOP;
      end else if (w_evt[2]) begin
         w_mode_n = (r_mode == MODE_SW) ? MODE_CLK : MODE_SW;
         if (r_mode == MODE_CLK) w_field_n = FIELD_NONE;
      end else if (w_evt[3] && r_mode == MODE_CLK) begin
         w_field_n = next_field(r_field);
      end
      if (|w_evt || r_field == FIELD_NONE) begin
         w_cnt_n = '0;
      end else if (r_cnt == CW'(EDIT_TIMEOUT - 1)) begin
         w_cnt_n   = '0;
         w_field_n = FIELD_NONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SW_STOP;
         r_mode  <= MODE_SW;
         r_field <= FIELD_NONE;
         r_cnt   <= '0;
         r_clear <= 1'b0;
         r_inc   <= 1'b0;
         r_dec   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_mode  <= w_mode_n;
         r_field <= w_field_n;
         r_cnt   <= w_cnt_n;
         r_clear <= w_clear_n;
         r_inc   <= w_inc_n;
         r_dec   <= w_dec_n;
      end
   end

   assign o_sw_run     = (r_state == SW_RUN);
   assign o_sw_clear   = r_clear;
   assign o_mode       = r_mode;
   assign o_edit_field = r_field;
   assign o_inc        = r_inc;
   assign o_dec        = r_dec;
endmodule
